// File: rtl/i281_ctrl_pkg.sv
// Shared encodings for the i281 multicycle control unit: state codes, opcode
// indices, control-word bit masks and small decode helpers.
package i281_ctrl_pkg;

    typedef enum logic [4:0] {
        S_IF         = 5'd0,
        S_ID         = 5'd1,
        S_EX_ALU     = 5'd2,
        S_EX_ADDR    = 5'd3,
        S_EX_BRANCH  = 5'd4,
        S_EX_JUMP    = 5'd5,
        S_MEM_READ   = 5'd6,
        S_MEM_WRITE  = 5'd7,
        S_WB_ALU     = 5'd8,
        S_WB_LOAD    = 5'd9,
        S_EX_LOAD    = 5'd10,
        S_EX_LOADI   = 5'd11,
        S_EX_LIR     = 5'd12,
        S_EX_MOVE    = 5'd13,
        S_EX_SWAPREG = 5'd14,
        S_IDLE       = 5'd15,
        S_FAULT      = 5'd16
    } state_t;

    localparam int NUM_OPS = 23;
    typedef logic [4:0] op_t;

    localparam op_t OP_NOOP    = 5'd0;
    localparam op_t OP_INPUTC  = 5'd1;
    localparam op_t OP_INPUTCF = 5'd2;
    localparam op_t OP_INPUTD  = 5'd3;
    localparam op_t OP_INPUTDF = 5'd4;
    localparam op_t OP_MOVE    = 5'd5;
    localparam op_t OP_LOADI   = 5'd6;
    localparam op_t OP_ADD     = 5'd7;
    localparam op_t OP_ADDI    = 5'd8;
    localparam op_t OP_SUB     = 5'd9;
    localparam op_t OP_SUBI    = 5'd10;
    localparam op_t OP_LOAD    = 5'd11;
    localparam op_t OP_LOADF   = 5'd12;
    localparam op_t OP_STORE   = 5'd13;
    localparam op_t OP_STOREF  = 5'd14;
    localparam op_t OP_SHIFTL  = 5'd15;
    localparam op_t OP_SHIFTR  = 5'd16;
    localparam op_t OP_CMP     = 5'd17;
    localparam op_t OP_JUMP    = 5'd18;
    localparam op_t OP_BRE     = 5'd19;
    localparam op_t OP_BRNE    = 5'd20;
    localparam op_t OP_BRG     = 5'd21;
    localparam op_t OP_BRGE    = 5'd22;

    // ALU select bits that depend on the opcode during ExALU/ExADDR
    localparam int C_ALU_S0 = 12;
    localparam int C_ALU_S1 = 13;

    localparam logic [NUM_OPS-1:0] ALU_S0_OPS =
        (23'd1 << OP_INPUTCF) | (23'd1 << OP_INPUTD) | (23'd1 << OP_INPUTDF) |
        (23'd1 << OP_ADD) | (23'd1 << OP_ADDI) | (23'd1 << OP_SUB) |
        (23'd1 << OP_SUBI) | (23'd1 << OP_LOADF) | (23'd1 << OP_STOREF) |
        (23'd1 << OP_CMP);
    localparam logic [NUM_OPS-1:0] ALU_S1_OPS =
        (23'd1 << OP_SUB) | (23'd1 << OP_SUBI) | (23'd1 << OP_SHIFTR) |
        (23'd1 << OP_CMP);

    function automatic logic [24:1] cb(input int k);
        logic [24:1] w;
        w = '0;
        w[k] = 1'b1;
        return w;
    endfunction

    localparam logic [24:1] C_IF         = cb(3) | cb(12) | cb(16) | cb(20) | cb(22);
    localparam logic [24:1] C_ID         = cb(3) | cb(11) | cb(12) | cb(15) | cb(22);
    localparam logic [24:1] C_EX_ALU     = cb(14) | cb(21) | cb(22) | cb(24);
    localparam logic [24:1] C_EX_ADDR    = cb(14) | cb(22) | cb(24);
    localparam logic [24:1] C_EX_LOAD    = cb(12) | cb(14) | cb(19) | cb(22) | cb(24);
    localparam logic [24:1] C_EX_MOVE    = cb(12) | cb(14) | cb(19) | cb(20) | cb(22) | cb(24);
    localparam logic [24:1] C_EX_LOADI   = cb(12) | cb(19) | cb(22) | cb(24);
    localparam logic [24:1] C_EX_JUMP    = cb(2) | cb(3);
    localparam logic [24:1] C_EX_LIR     = cb(11);
    localparam logic [24:1] C_EX_SWAPREG = cb(11) | cb(15);
    localparam logic [24:1] C_MEM_READ   = cb(23);
    localparam logic [24:1] C_MEM_WRITE  = cb(17);
    localparam logic [24:1] C_WB_ALU     = cb(10);
    localparam logic [24:1] C_WB_LOAD    = cb(10) | cb(18);

    function automatic logic [24:1] c_word(input state_t s, input op_t op);
        logic [24:1] w;
        w = '0;
        case (s)
            S_IF:         w = C_IF;
            S_ID:         w = C_ID;
            S_EX_ALU, S_EX_ADDR: begin
                w = (s == S_EX_ALU) ? C_EX_ALU : C_EX_ADDR;
                w[C_ALU_S0] = ALU_S0_OPS[op];
                w[C_ALU_S1] = ALU_S1_OPS[op];
            end
            S_EX_LOAD:    w = C_EX_LOAD;
            S_EX_MOVE:    w = C_EX_MOVE;
            S_EX_LOADI:   w = C_EX_LOADI;
            S_EX_JUMP:    w = C_EX_JUMP;
            S_EX_LIR:     w = C_EX_LIR;
            S_EX_SWAPREG: w = C_EX_SWAPREG;
            S_MEM_READ:   w = C_MEM_READ;
            S_MEM_WRITE:  w = C_MEM_WRITE;
            S_WB_ALU:     w = C_WB_ALU;
            S_WB_LOAD:    w = C_WB_LOAD;
            default:      w = '0;
        endcase
        return w;
    endfunction

    function automatic logic is_branch(input op_t op);
        return (op == OP_BRE) || (op == OP_BRNE) || (op == OP_BRG) || (op == OP_BRGE);
    endfunction

    // flags[0] = zero, flags[1] = negative
    function automatic logic branch_taken(input op_t op, input logic [1:0] flags);
        logic t;
        case (op)
            OP_BRE:  t = flags[0];
            OP_BRNE: t = !flags[0];
            OP_BRG:  t = !flags[0] && !flags[1];
            OP_BRGE: t = !flags[1];
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    function automatic logic operands_swapped(input op_t op);
        return (op == OP_MOVE) || (op == OP_LOADF) || (op == OP_STORE) || (op == OP_STOREF);
    endfunction

    function automatic logic is_final(input state_t s, input op_t op, input logic taken);
        logic f;
        case (s)
            S_ID:                            f = (op == OP_NOOP) || (is_branch(op) && !taken);
            S_EX_ALU:                        f = (op == OP_CMP);
            S_WB_ALU:                        f = (op != OP_LOADF);
            S_EX_JUMP, S_WB_LOAD, S_MEM_WRITE: f = 1'b1;
            default:                         f = 1'b0;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/i281_op_decode.sv
// One-hot opcode field to opcode index; anything other than exactly one bit
// set is flagged illegal and reported as NOOP.
module i281_op_decode
    import i281_ctrl_pkg::*;
(
    input  logic [NUM_OPS-1:0] onehot,
    output op_t                op,
    output logic               illegal
);
    logic [4:0] ones;
    op_t        idx;

    always_comb begin
        ones = '0;
        idx  = OP_NOOP;
        for (int i = 0; i < NUM_OPS; i++) begin
            if (onehot[i]) begin
                ones = ones + 5'd1;
                idx  = op_t'(i);
            end
        end
    end

    assign illegal = (ones != 5'd1);
    assign op      = illegal ? OP_NOOP : idx;
endmodule

// File: rtl/i281_ctrl_fsm_step.sv
// Multicycle i281 control FSM with run/step gating, memory wait states with
// timeout fault, branches, illegal-opcode trap and a retire pulse.
module i281_ctrl_fsm_step
    import i281_ctrl_pkg::*;
#(
    parameter int REG_SEL_W    = 2,
    parameter int MEM_WAIT_MAX = 15,
    parameter int ILLEGAL_TRAP = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       run,
    input  logic                       step,
    input  logic [22+2*REG_SEL_W:0]    opcode_in,
    input  logic [3:0]                 flags_reg,
    input  logic                       mem_ready,
    output logic [24:1]                c,
    output logic [REG_SEL_W-1:0]       sel_a,
    output logic [REG_SEL_W-1:0]       sel_b,
    output logic [REG_SEL_W-1:0]       wr_sel,
    output logic                       mem_req,
    output logic                       busy,
    output logic                       retire,
    output logic                       fault,
    output logic [4:0]                 state_dbg
);
    localparam int CW = $clog2(MEM_WAIT_MAX + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_WAIT_MAX - 1);
    localparam logic TRAP = (ILLEGAL_TRAP != 0);

    state_t               state, nxt;
    logic [CW-1:0]        wait_cnt;
    op_t                  op_q, dec_op, e_op;
    logic                 illegal_q, dec_illegal, e_illegal;
    logic                 taken_q, e_taken, enter_id, retire_q, n_retire;
    logic [REG_SEL_W-1:0] rx_q, ry_q, e_rx, e_ry, n_sel_a, n_sel_b, n_wr_sel;
    logic                 unused_flags;

    assign unused_flags = ^flags_reg[3:2];

    i281_op_decode u_decode (
        .onehot  (opcode_in[NUM_OPS-1:0]),
        .op      (dec_op),
        .illegal (dec_illegal)
    );

    // Instruction word and flags are captured on the edge that enters ID, so
    // every output can be registered against the state being entered.
    assign enter_id  = (state == S_IF);
    assign e_op      = enter_id ? dec_op : op_q;
    assign e_illegal = enter_id ? dec_illegal : illegal_q;
    assign e_rx      = enter_id ? opcode_in[22+2*REG_SEL_W -: REG_SEL_W] : rx_q;
    assign e_ry      = enter_id ? opcode_in[22+REG_SEL_W -: REG_SEL_W] : ry_q;
    assign e_taken   = enter_id ? branch_taken(dec_op, flags_reg[1:0]) : taken_q;

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE: if (run || step) nxt = S_IF;
            S_IF:   nxt = S_ID;
            S_ID: begin
                if (illegal_q && TRAP) nxt = S_FAULT;
                else begin
                    case (op_q)
                        OP_NOOP:                          nxt = run ? S_IF : S_IDLE;
                        OP_MOVE:                          nxt = S_EX_MOVE;
                        OP_LOADI:                         nxt = S_EX_LOADI;
                        OP_ADDI, OP_SUBI:                 nxt = S_EX_ADDR;
                        OP_LOAD, OP_LOADF, OP_STORE:      nxt = S_EX_LOAD;
                        OP_STOREF:                        nxt = S_EX_SWAPREG;
                        OP_JUMP:                          nxt = S_EX_JUMP;
                        OP_BRE, OP_BRNE, OP_BRG, OP_BRGE: nxt = taken_q ? S_EX_JUMP : (run ? S_IF : S_IDLE);
                        OP_INPUTC, OP_INPUTCF, OP_INPUTD, OP_INPUTDF, OP_ADD, OP_SUB,
                        OP_SHIFTL, OP_SHIFTR, OP_CMP:     nxt = S_EX_ALU;
                        default:                          nxt = S_FAULT;
                    endcase
                end
            end
            S_EX_MOVE, S_EX_ADDR: nxt = S_WB_ALU;
            S_EX_LOADI:   nxt = (op_q == OP_STOREF) ? S_MEM_WRITE : S_WB_ALU;
            S_EX_ALU: begin
                if (op_q == OP_CMP)        nxt = run ? S_IF : S_IDLE;
                else if (op_q == OP_LOADF) nxt = S_MEM_READ;
                else                       nxt = S_WB_ALU;
            end
            S_EX_LOAD: begin
                if (op_q == OP_LOADF)      nxt = S_WB_ALU;
                else if (op_q == OP_STORE) nxt = S_MEM_WRITE;
                else                       nxt = S_MEM_READ;
            end
            S_WB_ALU:     nxt = (op_q == OP_LOADF) ? S_EX_LIR : (run ? S_IF : S_IDLE);
            S_EX_LIR:     nxt = S_EX_ALU;
            S_EX_SWAPREG: nxt = S_EX_LOADI;
            S_MEM_READ: begin
                if (mem_ready)                  nxt = S_WB_LOAD;
                else if (wait_cnt == WAIT_LAST) nxt = S_FAULT;
            end
            S_MEM_WRITE: begin
                if (mem_ready)                  nxt = run ? S_IF : S_IDLE;
                else if (wait_cnt == WAIT_LAST) nxt = S_FAULT;
            end
            S_EX_JUMP, S_WB_LOAD: nxt = run ? S_IF : S_IDLE;
            S_FAULT:      nxt = S_FAULT;
            default:      nxt = S_FAULT;
        endcase
    end

    always_comb begin
        n_sel_a  = '0;
        n_sel_b  = '0;
        n_wr_sel = '0;
        case (nxt)
            S_ID: begin
                n_sel_a = operands_swapped(e_op) ? e_ry : e_rx;
                n_sel_b = operands_swapped(e_op) ? e_rx : e_ry;
            end
            S_EX_LIR:     n_sel_a = e_rx;
            S_EX_SWAPREG: begin
                n_sel_a = e_ry;
                n_sel_b = e_rx;
            end
            S_WB_ALU, S_WB_LOAD: n_wr_sel = e_rx;
            default: ;
        endcase
        n_retire = is_final(nxt, e_op, e_taken) && !((nxt == S_ID) && e_illegal && TRAP);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            wait_cnt  <= '0;
            op_q      <= OP_NOOP;
            illegal_q <= 1'b0;
            taken_q   <= 1'b0;
            rx_q      <= '0;
            ry_q      <= '0;
            c         <= '0;
            sel_a     <= '0;
            sel_b     <= '0;
            wr_sel    <= '0;
            mem_req   <= 1'b0;
            busy      <= 1'b0;
            retire_q  <= 1'b0;
            fault     <= 1'b0;
        end else begin
            state    <= nxt;
            wait_cnt <= ((state == S_MEM_READ || state == S_MEM_WRITE) && nxt == state)
                        ? wait_cnt + CW'(1) : '0;
            if (enter_id) begin
                op_q      <= e_op;
                illegal_q <= e_illegal;
                taken_q   <= e_taken;
                rx_q      <= e_rx;
                ry_q      <= e_ry;
            end
            c        <= c_word(nxt, e_op);
            sel_a    <= n_sel_a;
            sel_b    <= n_sel_b;
            wr_sel   <= n_wr_sel;
            mem_req  <= (nxt == S_MEM_READ) || (nxt == S_MEM_WRITE);
            busy     <= (nxt != S_IDLE) && (nxt != S_FAULT);
            retire_q <= n_retire;
            fault    <= (nxt == S_FAULT);
        end
    end

    // A final Mem state may stretch over wait cycles; retire only on completion.
    assign retire    = retire_q && (!mem_req || mem_ready);
    assign state_dbg = state;
endmodule

// File: tb/tb_i281_ctrl_fsm_step.sv
// Directed bench for i281_ctrl_fsm_step: one DUT traps illegal opcodes, the
// other runs them as NOOP; both share every input.
module tb_i281_ctrl_fsm_step;
    import i281_ctrl_pkg::*;

    logic        clock = 1'b0;
    logic        reset, run, step, mem_ready;
    logic [26:0] opcode_in;
    logic [3:0]  flags_reg;

    logic [24:1] t_c, n_c;
    logic [1:0]  t_sel_a, t_sel_b, t_wr_sel, n_sel_a, n_sel_b, n_wr_sel;
    logic        t_mem_req, t_busy, t_retire, t_fault;
    logic        n_mem_req, n_busy, n_retire, n_fault;
    logic [4:0]  t_state, n_state;

    int   checks = 0;
    int   errors = 0;
    logic saw_retire;

    i281_ctrl_fsm_step #(.REG_SEL_W(2), .MEM_WAIT_MAX(15), .ILLEGAL_TRAP(1)) dut (
        .clock(clock), .reset(reset), .run(run), .step(step), .opcode_in(opcode_in),
        .flags_reg(flags_reg), .mem_ready(mem_ready), .c(t_c), .sel_a(t_sel_a),
        .sel_b(t_sel_b), .wr_sel(t_wr_sel), .mem_req(t_mem_req), .busy(t_busy),
        .retire(t_retire), .fault(t_fault), .state_dbg(t_state)
    );

    i281_ctrl_fsm_step #(.REG_SEL_W(2), .MEM_WAIT_MAX(15), .ILLEGAL_TRAP(0)) dut_nt (
        .clock(clock), .reset(reset), .run(run), .step(step), .opcode_in(opcode_in),
        .flags_reg(flags_reg), .mem_ready(mem_ready), .c(n_c), .sel_a(n_sel_a),
        .sel_b(n_sel_b), .wr_sel(n_wr_sel), .mem_req(n_mem_req), .busy(n_busy),
        .retire(n_retire), .fault(n_fault), .state_dbg(n_state)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_st(input string tag, input logic [4:0] obs, input state_t exp);
        chk(tag, 32'(obs), 32'(exp));
    endtask

    task automatic chk_c(input string tag, input logic [24:1] obs, input logic [23:0] exp);
        chk(tag, 32'(obs), 32'(exp));
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        chk(tag, 32'(obs), 32'(exp));
    endtask

    task automatic chk_sel(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        chk(tag, 32'(obs), 32'(exp));
    endtask

    function automatic logic [26:0] mk(input op_t op, input logic [1:0] rx, input logic [1:0] ry);
        logic [22:0] oh;
        oh = '0;
        oh[op] = 1'b1;
        return {rx, ry, oh};
    endfunction

    initial begin
        reset = 1'b1; run = 1'b0; step = 1'b0; mem_ready = 1'b0;
        opcode_in = '0; flags_reg = '0;
        tick(); tick();
        chk_st("rst_state", t_state, S_IDLE);
        chk_c("rst_c", t_c, 24'h0);
        chk1("rst_busy", t_busy, 1'b0);
        chk1("rst_fault", t_fault, 1'b0);
        chk1("rst_retire", t_retire, 1'b0);
        chk1("rst_mem_req", t_mem_req, 1'b0);

        // ADD RX=2 RY=1, free-running
        reset = 1'b0; run = 1'b1; opcode_in = mk(OP_ADD, 2'd2, 2'd1);
        tick();
        chk_st("add_if", t_state, S_IF);
        chk_c("add_if_c", t_c, 24'h288804);
        chk1("add_if_busy", t_busy, 1'b1);
        tick();
        chk_st("add_id", t_state, S_ID);
        chk_c("add_id_c", t_c, 24'h204C04);
        chk_sel("add_id_sel_a", t_sel_a, 2'd2);
        chk_sel("add_id_sel_b", t_sel_b, 2'd1);
        tick();
        chk_st("add_exalu", t_state, S_EX_ALU);
        chk_c("add_exalu_c", t_c, 24'hB02800);
        tick();
        chk_st("add_wb", t_state, S_WB_ALU);
        chk_c("add_wb_c", t_c, 24'h000200);
        chk_sel("add_wb_wr_sel", t_wr_sel, 2'd2);
        chk1("add_wb_retire", t_retire, 1'b1);
        tick();
        chk_st("add_back_if", t_state, S_IF);
        chk1("add_retire_gone", t_retire, 1'b0);
        run = 1'b0;
        tick(); tick(); tick(); tick();
        chk_st("add_drain_idle", t_state, S_IDLE);
        chk1("add_drain_busy", t_busy, 1'b0);

        // CMP single step: ExALU is final, both ALU select bits set
        opcode_in = mk(OP_CMP, 2'd1, 2'd0);
        step = 1'b1; tick(); step = 1'b0;
        chk_st("cmp_if", t_state, S_IF);
        tick(); tick();
        chk_st("cmp_exalu", t_state, S_EX_ALU);
        chk_c("cmp_exalu_c", t_c, 24'hB03800);
        chk1("cmp_retire", t_retire, 1'b1);
        tick();
        chk_st("cmp_idle", t_state, S_IDLE);

        // LOAD single step with three wait cycles; a step while busy is ignored
        opcode_in = mk(OP_LOAD, 2'd1, 2'd3); mem_ready = 1'b0;
        step = 1'b1; tick(); step = 1'b0;
        tick();
        step = 1'b1; tick(); step = 1'b0;
        chk_st("load_exload", t_state, S_EX_LOAD);
        chk_c("load_exload_c", t_c, 24'hA42800);
        tick();
        chk_st("load_mem1", t_state, S_MEM_READ);
        chk1("load_mem1_req", t_mem_req, 1'b1);
        chk_c("load_mem1_c", t_c, 24'h400000);
        tick(); tick(); tick();
        mem_ready = 1'b1;
        chk_st("load_mem4", t_state, S_MEM_READ);
        chk1("load_mem4_req", t_mem_req, 1'b1);
        chk1("load_mem4_retire", t_retire, 1'b0);
        tick();
        mem_ready = 1'b0;
        chk_st("load_wb", t_state, S_WB_LOAD);
        chk_c("load_wb_c", t_c, 24'h020200);
        chk_sel("load_wb_wr_sel", t_wr_sel, 2'd1);
        chk1("load_wb_retire", t_retire, 1'b1);
        tick();
        chk_st("load_idle", t_state, S_IDLE);
        chk1("load_idle_busy", t_busy, 1'b0);

        // STORE with memory never ready: timeout after 15 MemWRITE cycles
        opcode_in = mk(OP_STORE, 2'd0, 2'd2);
        step = 1'b1; tick(); step = 1'b0;
        tick();
        chk_sel("store_id_sel_a", t_sel_a, 2'd2);
        chk_sel("store_id_sel_b", t_sel_b, 2'd0);
        tick(); tick();
        chk_st("store_mem1", t_state, S_MEM_WRITE);
        chk_c("store_mem1_c", t_c, 24'h010000);
        saw_retire = t_retire;
        for (int i = 0; i < 14; i++) begin
            tick();
            saw_retire = saw_retire | t_retire;
        end
        chk_st("store_mem15", t_state, S_MEM_WRITE);
        tick();
        saw_retire = saw_retire | t_retire;
        chk_st("store_fault", t_state, S_FAULT);
        chk1("store_fault_flag", t_fault, 1'b1);
        chk1("store_fault_busy", t_busy, 1'b0);
        chk_c("store_fault_c", t_c, 24'h0);
        chk1("store_fault_mem_req", t_mem_req, 1'b0);
        chk1("store_no_retire", saw_retire, 1'b0);
        run = 1'b1; tick(); tick();
        chk_st("store_fault_held", t_state, S_FAULT);
        reset = 1'b1; run = 1'b0; tick(); reset = 1'b0;
        chk_st("store_reset_idle", t_state, S_IDLE);
        chk1("store_reset_fault", t_fault, 1'b0);

        // BRNE untaken then taken, BRG taken then untaken
        run = 1'b1; opcode_in = mk(OP_BRNE, 2'd0, 2'd0); flags_reg = 4'b0001;
        tick(); tick();
        chk_st("brne_nt_id", t_state, S_ID);
        chk1("brne_nt_retire", t_retire, 1'b1);
        flags_reg = 4'b0000;
        tick();
        chk_st("brne_nt_if", t_state, S_IF);
        tick();
        chk1("brne_t_id_retire", t_retire, 1'b0);
        tick();
        chk_st("brne_t_jump", t_state, S_EX_JUMP);
        chk_c("brne_t_jump_c", t_c, 24'h000006);
        chk1("brne_t_retire", t_retire, 1'b1);
        opcode_in = mk(OP_BRG, 2'd0, 2'd0);
        tick(); tick(); tick();
        chk_st("brg_t_jump", t_state, S_EX_JUMP);
        flags_reg = 4'b0010;
        tick(); tick();
        chk_st("brg_nt_id", t_state, S_ID);
        chk1("brg_nt_retire", t_retire, 1'b1);
        run = 1'b0;
        tick();
        chk_st("brg_nt_idle", t_state, S_IDLE);

        // Two bits set in the opcode field
        run = 1'b1; opcode_in = {2'd1, 2'd2, 23'h000003};
        tick(); tick();
        chk1("ill_trap_id_retire", t_retire, 1'b0);
        chk1("ill_nop_id_retire", n_retire, 1'b1);
        tick();
        chk_st("ill_trap_fault", t_state, S_FAULT);
        chk1("ill_trap_fault_flag", t_fault, 1'b1);
        chk_st("ill_nop_if", n_state, S_IF);
        chk1("ill_nop_fault_flag", n_fault, 1'b0);
        run = 1'b0;
        tick(); tick();
        chk_st("ill_nop_idle", n_state, S_IDLE);
        reset = 1'b1; tick(); reset = 1'b0;

        // Empty opcode field is illegal too
        opcode_in = '0;
        step = 1'b1; tick(); step = 1'b0;
        tick(); tick();
        chk_st("zero_op_fault", t_state, S_FAULT);
        reset = 1'b1; tick(); reset = 1'b0;

        // LOADF interrupted by reset in ExLIR
        run = 1'b1; opcode_in = mk(OP_LOADF, 2'd3, 2'd1);
        tick(); tick();
        chk_sel("loadf_id_sel_a", t_sel_a, 2'd1);
        chk_sel("loadf_id_sel_b", t_sel_b, 2'd3);
        tick();
        chk_st("loadf_exload", t_state, S_EX_LOAD);
        tick();
        chk_st("loadf_wb", t_state, S_WB_ALU);
        chk_sel("loadf_wb_wr_sel", t_wr_sel, 2'd3);
        chk1("loadf_wb_retire", t_retire, 1'b0);
        tick();
        chk_st("loadf_lir", t_state, S_EX_LIR);
        chk_c("loadf_lir_c", t_c, 24'h000400);
        chk_sel("loadf_lir_sel_a", t_sel_a, 2'd3);
        reset = 1'b1;
        tick();
        chk_st("loadf_rst_state", t_state, S_IDLE);
        chk_c("loadf_rst_c", t_c, 24'h0);
        chk_sel("loadf_rst_sel_a", t_sel_a, 2'd0);
        chk1("loadf_rst_retire", t_retire, 1'b0);
        chk1("loadf_rst_busy", t_busy, 1'b0);
        reset = 1'b0; run = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/i281_ctrl_fsm_step.md
Name: i281_ctrl_fsm_step

Overview:
- Parametrised multicycle control FSM for the i281 CPU.
- Decodes the one-hot opcode word plus the RX/RY fields and sequences IF/ID/Ex/Mem/Wb states. Drives the datapath control word and separate register-select buses.
- New over the current control unit:
  - run/single-step gating at instruction boundaries
  - memory wait-state handshake with timeout fault
  - BRE/BRNE branch support
  - illegal-opcode trap
  - retire pulse

Parameters:
REG_SEL_W, 2, width of each RX/RY register-select field (register file depth 2**REG_SEL_W)
MEM_WAIT_MAX, 15, max cycles a Mem state waits for mem_ready before FAULT (>=1)
ILLEGAL_TRAP, 1, 1: non-one-hot opcode enters FAULT; 0: executes as NOOP

Ports:
clock  input  1  single clock, rising edge
reset  input  1  synchronous, active-high
run  input  1  level; 1 = free-run
step  input  1  one-cycle pulse; executes exactly one instruction from IDLE
opcode_in  input  23+2*REG_SEL_W  [22:0] one-hot op (bit order NOOP..BRGE), next REG_SEL_W = RY, top REG_SEL_W = RX
flags_reg  input  4  [0]=zero, [1]=negative; sampled in ID
mem_ready  input  1  data memory completes access this cycle
c  output  24  control word c[24:1]; bits 4-9 tied 0 (replaced by select buses)
sel_a, sel_b, wr_sel  output  REG_SEL_W each  register read/write selects
mem_req  output  1  high in MemREAD/MemWRITE
busy  output  1  state != IDLE and != FAULT
retire  output  1  one-cycle pulse on an instruction's final state
fault  output  1  sticky, high in FAULT
state_dbg  output  5  current state code

Behaviour:
- States: IF, ID, ExALU, ExADDR, ExBRANCH(reserved), ExJUMP, MemREAD, MemWRITE, WbALU, WbLOAD, ExLOAD, ExLOADI, ExLIR, ExMOVE, ExSWAPREG, IDLE, FAULT.
- Reset:
  - next edge: state=IDLE, wait counter=0.
  - All outputs 0. fault=0 only via reset.
  - Overrides any state, including mid-Mem wait.
- IDLE -> IF when run|step. IDLE outputs all 0.
- Instruction paths after ID:
  - NOOP -> IF
  - MOVE: ExMOVE, WbALU
  - LOADI: ExLOADI, WbALU
  - ADD/SUB: ExALU, WbALU
  - ADDI/SUBI: ExADDR, WbALU
  - LOAD: ExLOAD, MemREAD, WbLOAD
  - LOADF: ExLOAD, WbALU, ExLIR, ExALU, MemREAD, WbLOAD
  - STORE: ExLOAD, MemWRITE
  - STOREF: ExSWAPREG, ExLOADI, MemWRITE
  - CMP: ExALU
  - JUMP: ExJUMP
  - INPUT*/SHIFT*: ExALU, WbALU
- Branches: taken -> ExJUMP, else -> final.
  - BRE: f0
  - BRNE: !f0
  - BRG: !f0 & !f1
  - BRGE: !f1
- Final state of each path (ID for NOOP/untaken branch): retire=1. Next state is IF if run, else IDLE.
- Mem states:
  - Wait counter clears on entry; stay while !mem_ready.
  - mem_ready high on the entry cycle -> 1-cycle access.
  - Counter reaching MEM_WAIT_MAX without mem_ready -> FAULT, no retire.
- Illegal opcode (zero or multiple bits set) in ID:
  - ILLEGAL_TRAP=1 -> FAULT.
  - ILLEGAL_TRAP=0 -> NOOP.
- FAULT: all controls 0, fault=1, held until reset.
- c bits asserted per state (others 0):
  - IF 3,12,16,20,22
  - ID 3,11,12,15,22
  - ExALU 12*,13*,14,21,22,24
  - ExADDR 12*,13*,14,22,24
  - ExLOAD 12,14,19,22,24
  - ExMOVE 12,14,19,20,22,24
  - ExLOADI 12,19,22,24
  - ExJUMP 2,3
  - ExLIR 11
  - ExSWAPREG 11,15
  - MemREAD 23
  - MemWRITE 17
  - WbALU 10
  - WbLOAD 10,18
- 12* = op in {INPUTCF,INPUTD,INPUTDF,ADD,ADDI,SUB,SUBI,LOADF,STOREF,CMP}; 13* = op in {SUB,SUBI,SHIFTR,CMP}.
- Selects:
  - ID: sel_a=RX, sel_b=RY; swapped (sel_a=RY, sel_b=RX) for MOVE/LOADF/STORE/STOREF.
  - ExLIR: sel_a=RX.
  - ExSWAPREG: sel_a=RY, sel_b=RX.
  - WbALU/WbLOAD: wr_sel=RX.
  - All other states: selects 0.
- run deasserted mid-instruction: the instruction completes, then IDLE. step while busy is ignored.

Decomposition:
- Package i281_ctrl_pkg: state codes, op indices, c-bit index constants, ALU-select op masks.
- Sub-module i281_op_decode: combinational one-hot -> op index + illegal flag.

Test Plan:
- reset, run=1, ADD RX=2 RY=1: IF,ID,ExALU,WbALU. In ID sel_a=2, sel_b=1; in WbALU wr_sel=2, c[10]=1; retire pulse; back to IF.
- run=0, step pulse, LOAD, mem_ready low 3 cycles: MemREAD held 4 cycles with mem_req=1, then WbLOAD c[10]=c[18]=1, retire, IDLE.
- MEM_WAIT_MAX=15, STORE with mem_ready=0 forever: FAULT after 15 MemWRITE cycles, fault=1, busy=0, c=0; reset clears.
- BRNE: flags=0001 -> ID->IF (not taken); flags=0000 -> ExJUMP with c[2]=c[3]=1. Repeat BRG with flags 0000/0010.
- opcode one-hot field=0x000003: ILLEGAL_TRAP=1 -> FAULT; ILLEGAL_TRAP=0 -> retire in ID, IF next.
- reset asserted during ExLIR of LOADF: next edge state=IDLE, all outputs 0, no retire.
